onehot_rr_arbiter: RTL

//  Round-robin arbiter directly upstream of the 8-to-3 encoder. Captures request pulses

---
 rtl/onehot_rr_arbiter_pkg.sv | 12 +
 rtl/onehot_rr_arbiter_rr_pick.sv | 33 +++
 rtl/onehot_rr_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/onehot_rr_arbiter_pkg.sv
// Shared types and constants for the one-hot round-robin arbiter.
// Pointer arithmetic relies on natural PW-bit wrap, so N must be a power of two.
package onehot_rr_arbiter_pkg;

    localparam int N_DEFAULT = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_t;

endpackage

// File: rtl/onehot_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: rotate by ptr, find lowest set bit, un-rotate.
module onehot_rr_arbiter_rr_pick #(
    parameter int N  = 8,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  cand,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic [N-1:0]  rot;
    logic [PW-1:0] first;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        rot    = '0;
        first  = '0;
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = cand[PW'(i) + ptr];
        end
        // Descending scan so the lowest set bit (closest to ptr) is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) first = PW'(i);
        end
        any = |rot;
        idx = first + ptr;
        if (any) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter: sticky pending bits, registered one-hot grant held under
// a valid/ready handshake, rotation pointer advanced past each accepted winner.
module onehot_rr_arbiter
    import onehot_rr_arbiter_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_onehot_o,
    output logic         gnt_valid_o,
    input  logic         gnt_ready_i,
    output logic [N-1:0] pend_o
);

    localparam int PW = $clog2(N);

    arb_state_t    state;
    logic [N-1:0]  pend;
    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt_idx;

    logic          xfer;
    logic [N-1:0]  pend_next;
    logic [PW-1:0] next_ptr;
    logic [N-1:0]  pick_cand;
    logic [PW-1:0] pick_ptr;
    logic [N-1:0]  pick_onehot;
    logic [PW-1:0] pick_idx;
    logic          pick_any;

    always_comb begin
        xfer      = gnt_valid_o & gnt_ready_i;
        // A request arriving in the acceptance cycle re-arms the bit (set beats clear).
        pend_next = (pend & ~(xfer ? gnt_onehot_o : '0)) | req_i;
        next_ptr  = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
        // While offering, the next winner is searched past the current one, excluding it.
        if (state == OFFER) begin
            pick_cand = pend & ~gnt_onehot_o;
            pick_ptr  = next_ptr;
        end else begin
            pick_cand = pend;
            pick_ptr  = ptr;
        end
    end

    onehot_rr_arbiter_rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .cand   (pick_cand),
        .ptr    (pick_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pend         <= '0;
            ptr          <= '0;
            gnt_idx      <= '0;
            gnt_onehot_o <= '0;
            gnt_valid_o  <= 1'b0;
        end else begin
            pend <= pend_next;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt_onehot_o <= pick_onehot;
                        gnt_idx      <= pick_idx;
                        gnt_valid_o  <= 1'b1;
                        state        <= OFFER;
                    end
                end
                OFFER: begin
                    if (xfer) begin
                        ptr <= next_ptr;
                        if (pick_any) begin
                            gnt_onehot_o <= pick_onehot;
                            gnt_idx      <= pick_idx;
                        end else begin
                            gnt_onehot_o <= '0;
                            gnt_valid_o  <= 1'b0;
                            state        <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pend_o = pend;

endmodule
